inst_buffer: RTL and testbench
==============================

# inst_buffer

Circular instruction queue that sits between instruction fetch and the decode stage. It accepts aligned fetch packets of up to FETCH_WIDTH 32-bit instructions and presents up to DECODE_WIDTH instructions per cycle, in program order, to the per-lane decode units. It is the producer end of the decode input interface. It also absorbs fetch/decode rate mismatch and discards all contents on a pipeline flush.

## Interface
- FETCH_WIDTH, 4: maximum instructions per fetch packet.
- DECODE_WIDTH, 4: decode lanes presented per cycle.
- DEPTH, 16: entries. Power of two, and DEPTH >= 2*FETCH_WIDTH.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries; takes priority over enqueue.
- fetch_valid  in  1  fetch packet offered.
- fetch_mask  in  FETCH_WIDTH  per-lane valid. Always contiguous from lane 0 (e.g. 0111); 0000 is legal and enqueues nothing.
- fetch_pc  in  32  PC of lane 0. Lane i PC = fetch_pc + 4*i.
- fetch_inst  in  FETCH_WIDTH*32  instruction words; lane i occupies bits [32*i+31 : 32*i].
- fetch_ready  out  1  packet will be accepted this cycle.
- dec_valid  out  DECODE_WIDTH  per-lane valid. Always contiguous from lane 0.
- dec_inst  out  DECODE_WIDTH*32  instruction words for decode.
- dec_pc  out  DECODE_WIDTH*32  PC per lane.
- dec_ready  in  1  decode consumes every lane flagged in dec_valid this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries (debug/perf).

## Operation
- Storage: DEPTH entries of {inst[31:0], pc[31:0]}.
- Pointers: head and tail of $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Empty when head == tail. Full when the low bits are equal and the wrap bits differ.
- count = tail - head, modulo 2^($clog2(DEPTH)+1).
- fetch_ready = !flush && (DEPTH - count >= FETCH_WIDTH). It is computed from the registered count only and does not depend on this cycle's dequeue, so there is no combinational path from dec_ready to fetch_ready.
- Enqueue fires when fetch_valid && fetch_ready. Lane i with fetch_mask[i] set is written to entry (tail + i) mod DEPTH. Tail advances by popcount(fetch_mask). Index arithmetic wraps modulo DEPTH.
- Presentation is combinational from storage. dec_valid[j] = (count > j). Lane j shows entry (head + j) mod DEPTH.
- Dequeue fires when dec_ready is high. Head advances by popcount(dec_valid), i.e. min(count, DECODE_WIDTH). dec_ready with dec_valid == 0 has no effect.
- Simultaneous enqueue and dequeue are both applied in the same cycle. count_next = count + enq_n - deq_n.
- flush: head, tail and count all go to 0 at the next edge, and any same-cycle enqueue or dequeue is dropped. Storage contents are not cleared.
- No instruction content is inspected here. Illegal or compressed encodings pass through unchanged to decode.

## Timing
- Reset values: head = tail = 0, count = 0, dec_valid = 0, fetch_ready = 1 (after the reset cycle). dec_inst and dec_pc are don't-care while their lane is invalid.
- While rst is high: fetch_ready = 0 and no enqueue occurs.
- Enqueue-to-visible latency: an instruction written at edge N appears on dec_* in the cycle after edge N, i.e. 1 cycle from fetch acceptance.
- Dequeue takes effect at the clock edge. The next lanes are visible in the following cycle.
- Full boundary: with count = DEPTH - FETCH_WIDTH + 1, fetch_ready = 0 even if decode drains this cycle.
- Wrap-around: a packet straddling index DEPTH-1 → 0 is written to both ends correctly, and presentation across the wrap keeps program order.
- Reset or flush mid-stream: dec_valid = 0 in the cycle after the edge. fetch_ready is high in that cycle (flush low).
- Throughput: sustained FETCH_WIDTH instructions per cycle when decode is always ready and DECODE_WIDTH >= FETCH_WIDTH.

## Test plan
- **Reset then single packet:** rst for 2 cycles. Then fetch_valid=1, mask=1111, pc=0x8000_0000, inst=0x00000013,0x00100093,0x00200113,0x00300193 with dec_ready=0.
  - Next cycle: dec_valid=1111, dec_pc=0x8000_0000/04/08/0C, count=4.
- **Fill to full:** dec_ready=0, push 4 full packets.
  - count=16, fetch_ready=0, and a 5th packet is not accepted.
  - Assert dec_ready for 1 cycle → count=12, fetch_ready=1.
- **Partial mask and wrap:** preload to head=tail=14 (count 0). Enqueue mask=0111 at pc=0x100.
  - Entries 14,15,0 are written; dec_valid=0111 with pc 0x100,0x104,0x108. tail=17 (wrap bit set).
- **Simultaneous enqueue/dequeue:** count=6, dec_ready=1, enqueue mask=1111.
  - Next cycle: count=6, and dec lane 0 holds the former 5th entry.
- **Flush priority:** count=8, flush=1 with fetch_valid=1 and dec_ready=1 in the same cycle.
  - Next cycle: count=0, dec_valid=0, and the flushed packet never appears.
- **Random stress:** random fetch_valid, mask, and dec_ready over 10k cycles against a reference queue model.
  - Dequeued (pc, inst) sequence matches in order. count never exceeds 16. No enqueue is lost while fetch_ready=1.

Source files
------------

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode.
//
// Accepts aligned fetch packets of up to FETCH_WIDTH instructions and presents up
// to DECODE_WIDTH instructions per cycle, oldest first, to the decode lanes.
// A flush discards every queued entry.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         drop all entries; wins over same-cycle enqueue and dequeue
//   fetch_valid   fetch packet offered
//   fetch_mask    per-lane valid, contiguous from lane 0
//   fetch_pc      PC of lane 0 (lane i is fetch_pc + 4*i)
//   fetch_inst    instruction words, lane i at [32*i +: 32]
//   fetch_ready   packet is accepted this cycle
//   dec_valid     per-lane valid toward decode, contiguous from lane 0
//   dec_inst      instruction words toward decode
//   dec_pc        PCs toward decode
//   dec_ready     decode consumes every valid lane this cycle
//   count         occupied entries
module inst_buffer #(
  parameter int unsigned FETCH_WIDTH  = 4,
  parameter int unsigned DECODE_WIDTH = 4,
  parameter int unsigned DEPTH        = 16,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned PW          = AW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [FETCH_WIDTH-1:0]     fetch_mask,
  input  logic [31:0]                fetch_pc,
  input  logic [FETCH_WIDTH*32-1:0]  fetch_inst,
  output logic                       fetch_ready,
  output logic [DECODE_WIDTH-1:0]    dec_valid,
  output logic [DECODE_WIDTH*32-1:0] dec_inst,
  output logic [DECODE_WIDTH*32-1:0] dec_pc,
  input  logic                       dec_ready,
  output logic [PW-1:0]              count
);

  localparam logic [PW-1:0] DepthP = PW'(DEPTH);
  localparam logic [PW-1:0] FetchP = PW'(FETCH_WIDTH);
  localparam logic [PW-1:0] DecP   = PW'(DECODE_WIDTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [31:0] inst_q [DEPTH];
  logic [31:0] inst_d [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [31:0] pc_d   [DEPTH];

  logic          enq;
  logic [PW-1:0] enq_n;
  logic [PW-1:0] deq_n;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign count = tail_q - head_q;

  // Depends only on registered pointers, so dec_ready never reaches fetch_ready.
  assign fetch_ready = !rst && !flush && ((DepthP - count) >= FetchP);
  assign enq         = fetch_valid && fetch_ready;

  always_comb begin
    enq_n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_n = enq_n + PW'(fetch_mask[i]);
    end
  end

  // Decode takes every presented lane, i.e. min(count, DECODE_WIDTH).
  always_comb begin
    deq_n = '0;
    if (dec_ready) begin
      deq_n = (count > DecP) ? DecP : count;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = head_q + deq_n;
      if (enq) begin
        tail_d = tail_q + enq_n;
      end
    end
  end

  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    wr_idx = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx = tail_q[AW-1:0] + AW'(i);
      if (enq && fetch_mask[i]) begin
        inst_d[wr_idx] = fetch_inst[32*i +: 32];
        pc_d[wr_idx]   = fetch_pc + 32'(4 * i);
      end
    end
  end

  always_comb begin
    dec_valid = '0;
    dec_inst  = '0;
    dec_pc    = '0;
    rd_idx    = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      rd_idx              = head_q[AW-1:0] + AW'(j);
      dec_valid[j]        = count > PW'(j);
      dec_inst[32*j +: 32] = inst_q[rd_idx];
      dec_pc[32*j +: 32]   = pc_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage is not reset; lanes beyond count are don't-care.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
  end

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  localparam int FW  = 4;
  localparam int DW  = 4;
  localparam int DEP = 16;

  logic              clk = 1'b0;
  logic              rst, flush, fetch_valid, dec_ready;
  logic [FW-1:0]     fetch_mask;
  logic [31:0]       fetch_pc;
  logic [FW*32-1:0]  fetch_inst;
  logic              fetch_ready;
  logic [DW-1:0]     dec_valid;
  logic [DW*32-1:0]  dec_inst, dec_pc;
  logic [4:0]        count;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] q[$];         // reference queue of {pc, inst}, oldest first
  bit          known = 1'b0; // model valid once a reset edge has been seen

  always #5 clk = ~clk;

  inst_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fetch_valid(fetch_valid),
    .fetch_mask (fetch_mask),
    .fetch_pc   (fetch_pc),
    .fetch_inst (fetch_inst),
    .fetch_ready(fetch_ready),
    .dec_valid  (dec_valid),
    .dec_inst   (dec_inst),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready),
    .count      (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FW*32-1:0] rand_ins();
    logic [FW*32-1:0] v;
    for (int i = 0; i < FW; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: drive, compare outputs against the queue model, update the model.
  task automatic step(input bit r, input bit fl, input bit fv, input logic [FW-1:0] m,
                      input logic [31:0] pc, input logic [FW*32-1:0] ins, input bit dr);
    int          sz;
    int          nd;
    bit          exp_rdy;
    logic [DW-1:0] ev;
    @(negedge clk);
    rst = r; flush = fl; fetch_valid = fv; fetch_mask = m;
    fetch_pc = pc; fetch_inst = ins; dec_ready = dr;
    #1;
    sz      = q.size();
    exp_rdy = !r && !fl && ((DEP - sz) >= FW);
    if (known) begin
      ev = '0;
      for (int j = 0; j < DW; j++) if (j < sz) ev[j] = 1'b1;
      check("fetch_ready", 64'(fetch_ready), 64'(exp_rdy));
      check("dec_valid", 64'(dec_valid), 64'(ev));
      check("count", 64'(count), 64'(sz));
      check("count_max", 64'(count > 5'(DEP)), 64'(0));
      for (int j = 0; j < DW; j++) begin
        if (j < sz) check("dec_lane", {dec_pc[32*j +: 32], dec_inst[32*j +: 32]}, q[j]);
      end
    end else if (r) begin
      check("rst_ready", 64'(fetch_ready), 64'(0));
    end
    @(posedge clk);
    if (r || fl) begin
      q.delete();
      if (r) known = 1'b1;
    end else if (known) begin
      nd = dr ? ((sz < DW) ? sz : DW) : 0;
      repeat (nd) void'(q.pop_front());
      if (fv && exp_rdy) begin
        for (int i = 0; i < FW; i++) begin
          if (m[i]) q.push_back({pc + 32'(4 * i), ins[32*i +: 32]});
        end
      end
    end
  endtask

  task automatic push(input logic [FW-1:0] m, input logic [31:0] pc, input bit dr);
    step(1'b0, 1'b0, 1'b1, m, pc, rand_ins(), dr);
  endtask

  task automatic idle(input bit dr);
    step(1'b0, 1'b0, 1'b0, '0, 32'h0, '0, dr);
  endtask

  initial begin
    int          n;
    logic [FW-1:0] m;

    // Reset then single packet
    step(1'b1, 1'b0, 1'b0, '0, 32'h0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 32'h0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'hF, 32'h8000_0000,
         {32'h0030_0193, 32'h0020_0113, 32'h0010_0093, 32'h0000_0013}, 1'b0);
    #1;
    check("pkt_count", 64'(count), 64'(4));
    check("pkt_valid", 64'(dec_valid), 64'(4'hF));
    check("pkt_pc0", 64'(dec_pc[31:0]), 64'(32'h8000_0000));
    check("pkt_pc3", 64'(dec_pc[127:96]), 64'(32'h8000_000C));
    check("pkt_inst1", 64'(dec_inst[63:32]), 64'(32'h0010_0093));

    // Fill to full, then a refused packet, then one drain cycle
    push(4'hF, 32'h1000, 1'b0);
    push(4'hF, 32'h1010, 1'b0);
    push(4'hF, 32'h1020, 1'b0);
    #1 check("full_count", 64'(count), 64'(16));
    push(4'hF, 32'h1030, 1'b0);
    #1 check("full_hold", 64'(count), 64'(16));
    idle(1'b1);
    #1;
    check("drain_count", 64'(count), 64'(12));
    check("drain_ready", 64'(fetch_ready), 64'(1));

    // Flush priority at count 8
    idle(1'b1);
    #1 check("pre_flush", 64'(count), 64'(8));
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'hDEAD_0000, rand_ins(), 1'b1);
    #1;
    check("flush_count", 64'(count), 64'(0));
    check("flush_valid", 64'(dec_valid), 64'(0));
    idle(1'b0);

    // Move head and tail to 14, then a packet straddling the wrap
    push(4'hF, 32'h2000, 1'b0);
    push(4'hF, 32'h2010, 1'b0);
    push(4'hF, 32'h2020, 1'b0);
    push(4'h3, 32'h2030, 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b1);
    #1 check("wrap_empty", 64'(count), 64'(0));
    push(4'h7, 32'h100, 1'b0);
    #1;
    check("wrap_valid", 64'(dec_valid), 64'(4'h7));
    check("wrap_pc0", 64'(dec_pc[31:0]), 64'(32'h100));
    check("wrap_pc1", 64'(dec_pc[63:32]), 64'(32'h104));
    check("wrap_pc2", 64'(dec_pc[95:64]), 64'(32'h108));

    // Simultaneous enqueue and dequeue at count 6
    push(4'h7, 32'h200, 1'b0);
    #1 check("sim_pre", 64'(count), 64'(6));
    push(4'hF, 32'h300, 1'b1);
    #1;
    check("sim_count", 64'(count), 64'(6));
    check("sim_lane0", 64'(dec_pc[31:0]), 64'(32'h204));

    // Random stress
    for (int c = 0; c < 10000; c++) begin
      n = $urandom_range(0, FW);
      m = FW'((1 << n) - 1);
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0), m, $urandom & 32'hFFFF_FFFC, rand_ins(),
           ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
